// File: rtl/smg_decode.sv
// ---------------------------------------------------------------------------
// smg_decode
//   Observes a multiplexed, active-low 7-segment display bus and recovers the
//   digit values it shows. Inputs are registered once. A digit is latched only
//   after its (segment, scan) pair has been seen identically for STABLE_CYC
//   consecutive samples. This rejects the ghosting that occurs while the scan
//   and segment lines change.
//
//   Optional feature macro: SMG_DECODE_DP_EN
//     defined   : DP_Flags[i] records the lit state of the dp segment at each
//                 latch of digit i
//     undefined : DP_Flags is constant 0 and the dp bit is ignored entirely
//
// Ports
//   CLK          in   clock, rising edge
//   RST          in   synchronous active-high reset
//   SMG_Data     in   [7:0] segment bus, active-low, bit7 = dp, bits6..0 = g..a
//   Scan_Sig     in   [NDIG-1:0] digit selects, active-low, one-hot-low valid
//   Number_Data  out  [4*NDIG-1:0] decoded nibbles, nibble i = digit i
//   Digit_Valid  out  [NDIG-1:0] nibble i holds a decimal value
//   DP_Flags     out  [NDIG-1:0] dp lit at digit i's last latch
//   Frame_Done   out  one-cycle pulse once every digit has latched
//   Err_Flag     out  sticky unrecognised-pattern flag
// ---------------------------------------------------------------------------
module smg_decode #(
    parameter int NDIG       = 6,
    parameter int STABLE_CYC = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [7:0]          SMG_Data,
    input  logic [NDIG-1:0]     Scan_Sig,
    output logic [4*NDIG-1:0]   Number_Data,
    output logic [NDIG-1:0]     Digit_Valid,
    output logic [NDIG-1:0]     DP_Flags,
    output logic                Frame_Done,
    output logic                Err_Flag
);

    localparam int         IW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [7:0] STABLE_C = 8'(STABLE_CYC);

    typedef enum logic [1:0] {IDLE, TRACK, LATCHED} state_t;

    state_t            state_q;
    logic [7:0]        seg_s_q, cap_seg_q;
    logic [NDIG-1:0]   scan_s_q, cap_scan_q;
    logic [7:0]        cnt_q;
    logic [4*NDIG-1:0] num_q;
    logic [NDIG-1:0]   vld_q, seen_q, seen_d;
    logic              done_q, err_q;

    logic [7:0]        seg_eff;
    logic [NDIG-1:0]   scan_inv;
    logic              onehot, same, latch_now, frame_full;
    logic [7:0]        cnt_inc;
    logic [IW-1:0]     idx;
    logic [3:0]        dec_nib;
    logic              dec_hit, blank;

`ifdef SMG_DECODE_DP_EN
    logic [NDIG-1:0]   dp_q;
    assign seg_eff = seg_s_q;
`else
    // dp is excluded from the stability compare as well as from the decode.
    // As a result, a flickering dp cannot hold off a latch.
    logic dp_unused;
    assign seg_eff   = {1'b1, seg_s_q[6:0]};
    assign dp_unused = ^{seg_s_q[7], cap_seg_q[7]};
`endif

    // A sampled scan is valid only when exactly one line is low.
    assign scan_inv   = ~scan_s_q;
    assign onehot     = (scan_inv != '0) && ((scan_inv & (scan_inv - NDIG'(1))) == '0);
    assign same       = (seg_eff == cap_seg_q) && (scan_s_q == cap_scan_q);
    assign cnt_inc    = cnt_q + 8'd1;
    assign latch_now  = (state_q == TRACK) && same && (cnt_inc == STABLE_C);
    assign frame_full = &seen_q;
    assign blank      = (cap_seg_q[6:0] == 7'h7F);

    always_comb begin
        idx = '0;
        for (int i = 0; i < NDIG; i++)
            if (!cap_scan_q[i]) idx = IW'(i);
    end

    always_comb begin
        dec_hit = 1'b1;
        dec_nib = 4'h0;
        case (cap_seg_q[6:0])
            7'h40: dec_nib = 4'd0;
            7'h79: dec_nib = 4'd1;
            7'h24: dec_nib = 4'd2;
            7'h30: dec_nib = 4'd3;
            7'h19: dec_nib = 4'd4;
            7'h12: dec_nib = 4'd5;
            7'h02: dec_nib = 4'd6;
            7'h78: dec_nib = 4'd7;
            7'h00: dec_nib = 4'd8;
            7'h10: dec_nib = 4'd9;
            default: dec_hit = 1'b0;
        endcase
    end

    // A full mask clears on the edge that emits Frame_Done. A latch on that
    // same edge is counted in the new frame.
    always_comb begin
        seen_d = frame_full ? '0 : seen_q;
        if (latch_now) seen_d[idx] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            seg_s_q    <= '1;
            scan_s_q   <= '1;
            cap_seg_q  <= '1;
            cap_scan_q <= '1;
            cnt_q      <= '0;
            num_q      <= '0;
            vld_q      <= '0;
            seen_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef SMG_DECODE_DP_EN
            dp_q       <= '0;
`endif
        end else begin
            seg_s_q  <= SMG_Data;
            scan_s_q <= Scan_Sig;
            done_q   <= frame_full;
            seen_q   <= seen_d;

            case (state_q)
                IDLE: begin
                    if (onehot) begin
                        state_q    <= TRACK;
                        cnt_q      <= 8'd1;
                        cap_seg_q  <= seg_eff;
                        cap_scan_q <= scan_s_q;
                    end
                end
                TRACK, LATCHED: begin
                    if (!onehot) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (!same) begin
                        state_q    <= TRACK;
                        cnt_q      <= 8'd1;
                        cap_seg_q  <= seg_eff;
                        cap_scan_q <= scan_s_q;
                    end else if (state_q == TRACK) begin
                        cnt_q <= cnt_inc;
                        if (latch_now) state_q <= LATCHED;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (latch_now) begin
                if (dec_hit) begin
                    num_q[4*idx +: 4] <= dec_nib;
                    vld_q[idx]        <= 1'b1;
                end else if (blank) begin
                    vld_q[idx]        <= 1'b0;
                end else begin
                    num_q[4*idx +: 4] <= 4'hF;
                    vld_q[idx]        <= 1'b0;
                    err_q             <= 1'b1;
                end
`ifdef SMG_DECODE_DP_EN
                dp_q[idx] <= ~cap_seg_q[7];
`endif
            end
        end
    end

    assign Number_Data = num_q;
    assign Digit_Valid = vld_q;
    assign Frame_Done  = done_q;
    assign Err_Flag    = err_q;
`ifdef SMG_DECODE_DP_EN
    assign DP_Flags    = dp_q;
`else
    assign DP_Flags    = '0;
`endif

endmodule

// File: tb/tb_smg_decode.sv
module tb_smg_decode;
    localparam int NDIG = 6;
    localparam int SC   = 4;

    logic              CLK = 1'b0;
    logic              RST;
    logic [7:0]        SMG_Data;
    logic [NDIG-1:0]   Scan_Sig;
    logic [4*NDIG-1:0] Number_Data;
    logic [NDIG-1:0]   Digit_Valid, DP_Flags;
    logic              Frame_Done, Err_Flag;

    smg_decode #(.NDIG(NDIG), .STABLE_CYC(SC)) dut (
        .CLK(CLK), .RST(RST), .SMG_Data(SMG_Data), .Scan_Sig(Scan_Sig),
        .Number_Data(Number_Data), .Digit_Valid(Digit_Valid), .DP_Flags(DP_Flags),
        .Frame_Done(Frame_Done), .Err_Flag(Err_Flag)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]  scan;
        logic [7:0]  seg;
        int          hold;
        logic [23:0] num;
        logic [5:0]  vld;
        logic [5:0]  dp;
        logic        err;
        int          frames;
    } vec_t;

    typedef struct {
        int   due;
        int   id;
        vec_t v;
    } exp_t;

    vec_t tbl [17];
    exp_t sbq [$];
    int   checks = 0, failures = 0;
    int   cyc = 0, frames = 0;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (Frame_Done === 1'b1) frames <= frames + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: each entry is due STABLE_CYC+1 edges after its drive.
    always @(negedge CLK) begin
        exp_t e;
        logic [5:0] edp;
        if (sbq.size() != 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
`ifdef SMG_DECODE_DP_EN
            edp = e.v.dp;
`else
            edp = '0;
`endif
            check($sformatf("v%0d num", e.id),    32'(Number_Data), 32'(e.v.num));
            check($sformatf("v%0d valid", e.id),  32'(Digit_Valid), 32'(e.v.vld));
            check($sformatf("v%0d dp", e.id),     32'(DP_Flags),    32'(edp));
            check($sformatf("v%0d err", e.id),    32'(Err_Flag),    32'(e.v.err));
            check($sformatf("v%0d frames", e.id), 32'(frames),      32'(e.v.frames));
        end
    end

    task automatic drive(input vec_t v, input int id);
        exp_t e;
        Scan_Sig = v.scan;
        SMG_Data = v.seg;
        e.due = cyc + SC + 1;
        e.id  = id;
        e.v   = v;
        sbq.push_back(e);
        repeat (v.hold) @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1; Scan_Sig = '1; SMG_Data = 8'hFF;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int  fsave;
        logic saw3;
        //          scan    seg    hold num        vld    dp     err   frames
        tbl[0]  = '{6'h3E, 8'hF9, 4,  24'h000001, 6'h01, 6'h00, 1'b0, 0};
        tbl[1]  = '{6'h3D, 8'hA4, 4,  24'h000021, 6'h03, 6'h00, 1'b0, 0};
        tbl[2]  = '{6'h3B, 8'hB0, 4,  24'h000321, 6'h07, 6'h00, 1'b0, 0};
        tbl[3]  = '{6'h37, 8'h99, 4,  24'h004321, 6'h0F, 6'h00, 1'b0, 0};
        tbl[4]  = '{6'h2F, 8'h92, 4,  24'h054321, 6'h1F, 6'h00, 1'b0, 0};
        tbl[5]  = '{6'h1F, 8'h82, 4,  24'h654321, 6'h3F, 6'h00, 1'b0, 0};
        tbl[6]  = '{6'h3F, 8'hFF, 3,  24'h654321, 6'h3F, 6'h00, 1'b0, 1};
        tbl[7]  = '{6'h3C, 8'hC0, 10, 24'h654321, 6'h3F, 6'h00, 1'b0, 1};
        tbl[8]  = '{6'h3D, 8'hAA, 6,  24'h6543F1, 6'h3D, 6'h00, 1'b1, 1};
        tbl[9]  = '{6'h3D, 8'hF8, 6,  24'h654371, 6'h3F, 6'h00, 1'b1, 1};
        tbl[10] = '{6'h37, 8'hFF, 6,  24'h654371, 6'h37, 6'h00, 1'b1, 1};
        tbl[11] = '{6'h3E, 8'h00, 6,  24'h654378, 6'h37, 6'h01, 1'b1, 1};
        tbl[12] = '{6'h3B, 8'h90, 6,  24'h654978, 6'h37, 6'h01, 1'b1, 1};
        tbl[13] = '{6'h2F, 8'hC0, 6,  24'h604978, 6'h37, 6'h01, 1'b1, 1};
        tbl[14] = '{6'h1F, 8'hFF, 6,  24'h604978, 6'h17, 6'h01, 1'b1, 1};
        tbl[15] = '{6'h3F, 8'hFF, 6,  24'h604978, 6'h17, 6'h01, 1'b1, 2};
        tbl[16] = '{6'h37, 8'h12, 6,  24'h605978, 6'h1F, 6'h09, 1'b1, 2};

        RST = 1'b1; Scan_Sig = '1; SMG_Data = 8'hFF;
        repeat (2) @(negedge CLK);
        check("reset num",   32'(Number_Data), 32'h0);
        check("reset valid", 32'(Digit_Valid), 32'h0);
        check("reset dp",    32'(DP_Flags),    32'h0);
        check("reset done",  32'(Frame_Done),  32'h0);
        check("reset err",   32'(Err_Flag),    32'h0);
        RST = 1'b0;
        @(negedge CLK);

        // Latency boundary: not valid after edge STABLE_CYC, valid after STABLE_CYC+1.
        Scan_Sig = 6'h3E; SMG_Data = 8'hC0;
        repeat (SC) @(negedge CLK);
        check("latency early valid", 32'(Digit_Valid), 32'h0);
        @(negedge CLK);
        check("latency valid",  32'(Digit_Valid), 32'h1);
        check("latency nibble", 32'(Number_Data[3:0]), 32'h0);
        Scan_Sig = '1; SMG_Data = 8'hFF;
        repeat (2) @(negedge CLK);

        // Pattern held one sample short of latching must never appear.
        saw3 = 1'b0;
        Scan_Sig = 6'h3B; SMG_Data = 8'hB0;
        repeat (3) begin @(negedge CLK); if (Number_Data[11:8] == 4'd3) saw3 = 1'b1; end
        SMG_Data = 8'hA4;
        repeat (4) begin @(negedge CLK); if (Number_Data[11:8] == 4'd3) saw3 = 1'b1; end
        Scan_Sig = '1; SMG_Data = 8'hFF;
        repeat (3) begin @(negedge CLK); if (Number_Data[11:8] == 4'd3) saw3 = 1'b1; end
        check("short hold nibble2", 32'(Number_Data[11:8]), 32'h2);
        check("short hold never 3", 32'(saw3), 32'h0);
        check("short hold valid",   32'(Digit_Valid), 32'h05);
        check("short hold frames",  32'(frames), 32'h0);

        do_reset();
        for (int i = 0; i < 17; i++) drive(tbl[i], i);
        Scan_Sig = '1; SMG_Data = 8'hFF;
        for (int i = 0; i < 50; i++) begin
            if (sbq.size() == 0) break;
            @(negedge CLK);
        end
        check("scoreboard drained", 32'(sbq.size()), 32'h0);

        // Reset on the very edge a latch is due.
        Scan_Sig = 6'h3E; SMG_Data = 8'hF9;
        repeat (SC) @(negedge CLK);
        RST = 1'b1; Scan_Sig = '1; SMG_Data = 8'hFF;
        @(negedge CLK);
        check("rst-latch num",   32'(Number_Data), 32'h0);
        check("rst-latch valid", 32'(Digit_Valid), 32'h0);
        check("rst-latch dp",    32'(DP_Flags),    32'h0);
        check("rst-latch err",   32'(Err_Flag),    32'h0);
        check("rst-latch done",  32'(Frame_Done),  32'h0);
        fsave = frames;
        RST = 1'b0;
        repeat (6) @(negedge CLK);
        check("post-rst num",    32'(Number_Data), 32'h0);
        check("post-rst valid",  32'(Digit_Valid), 32'h0);
        check("post-rst frames", 32'(frames),      32'(fsave));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
